hermes_switch_ctrl: RTL and testbench

Switch allocator for one Hermes router. Takes header requests from the five input buffers, picks one per decision round by round-robin, and computes its XY output port. It allocates that output if free, holds the input→output connection until the input buffer reports end of packet, and drives the crossbar select lines. One instance per router; the router's `ADDRESS` parameter is passed straight through.

---
 rtl/hermes_switch_ctrl.sv | 152 +++++++++++++++
 tb/tb_hermes_switch_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_switch_ctrl.sv
// hermes_switch_ctrl: switch allocator for one Hermes router.
// Picks one header request per round (round-robin), computes its XY output
// port, allocates that output if free and holds the connection until the
// input reports end of packet. Drives the crossbar select lines.
// Optional feature macro: HERMES_SWITCH_STATS_EN adds blocked_cnt_o, a
// saturating count of rounds lost to a busy output.
module hermes_switch_ctrl #(
  parameter int unsigned ADDRESS   = 0,
  parameter int          FLIT_SIZE = 16,
  parameter int          NPORT     = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NPORT-1:0]          req_i,
  input  logic [NPORT*FLIT_SIZE-1:0] head_i,
  input  logic [NPORT-1:0]          free_i,
  output logic [NPORT-1:0]          ack_o,
  output logic [NPORT-1:0]          out_en_o,
  output logic [NPORT*3-1:0]        out_src_o
`ifdef HERMES_SWITCH_STATS_EN
  ,
  output logic [15:0]               blocked_cnt_o
`endif
);

  // Port encoding shared by inputs and outputs.
  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [15:0] ADDR   = ADDRESS[15:0];
  localparam logic [7:0]  X_ADDR = ADDR[15:8];
  localparam logic [7:0]  Y_ADDR = ADDR[7:0];

  typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

  state_t           state;
  logic [2:0]       sel;
  logic [2:0]       last;

  logic             arb_found;
  logic [2:0]       arb_pick;
  logic [15:0]      sel_head;
  logic [2:0]       dir;
  logic [NPORT-1:0] release_mask;
  logic             dir_free;

  // Round-robin search starting one past the last served input, wrapping.
  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 1; k <= NPORT; k++) begin
      logic [2:0] idx;
      idx = 3'((int'(last) + k) % NPORT);
      if (!arb_found && req_i[idx]) begin
        arb_found = 1'b1;
        arb_pick  = idx;
      end
    end
  end

  // Header of the selected input.
  always_comb begin
    sel_head = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (sel == 3'(p)) sel_head = head_i[p*FLIT_SIZE +: 16];
    end
  end

  // XY routing: resolve X first, then Y, else deliver locally (unsigned).
  always_comb begin
    if (sel_head[15:8] > X_ADDR)      dir = EAST;
    else if (sel_head[15:8] < X_ADDR) dir = WEST;
    else if (sel_head[7:0] > Y_ADDR)  dir = NORTH;
    else if (sel_head[7:0] < Y_ADDR)  dir = SOUTH;
    else                              dir = LOCAL;
  end

  // Outputs whose current holder signals end of packet this cycle.
  always_comb begin
    release_mask = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (out_en_o[o] && free_i[out_src_o[o*3 +: 3]]) release_mask[o] = 1'b1;
    end
  end

  // A releasing holder counts as free so the output is re-granted without a gap.
  assign dir_free = !out_en_o[dir] || release_mask[dir];

  // Allocation FSM with registered grant, enable and select outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in this block override
  // earlier ones (new allocation wins over a same-edge release).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      sel       <= '0;
      last      <= LOCAL;
      ack_o     <= '0;
      out_en_o  <= '0;
      out_src_o <= '0;
`ifdef HERMES_SWITCH_STATS_EN
      blocked_cnt_o <= '0;
`endif
    end else begin
      ack_o    <= '0;
      out_en_o <= out_en_o & ~release_mask;
      case (state)
        IDLE: begin
          if (|req_i) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            sel   <= arb_pick;
            state <= ROUTE;
          end else begin
            state <= IDLE;
          end
        end
        ROUTE: begin
          if (!req_i[sel]) begin
            state <= IDLE;
          end else if (dir_free) begin
            out_en_o[dir] <= 1'b1;
            for (int o = 0; o < NPORT; o++) begin
              if (dir == 3'(o)) out_src_o[o*3 +: 3] <= sel;
            end
            ack_o[sel] <= 1'b1;
            last       <= sel;
            state      <= GRANT;
          end else begin
            // Blocked: still advance the pointer so others get a turn.
            last  <= sel;
            state <= IDLE;
`ifdef HERMES_SWITCH_STATS_EN
            if (blocked_cnt_o != 16'hFFFF) blocked_cnt_o <= blocked_cnt_o + 16'd1;
`endif
          end
        end
        GRANT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_switch_ctrl.sv
// Self-checking bench for hermes_switch_ctrl (router address 0x0101).
// Expected grants are pushed to a scoreboard queue when requests are driven
// and popped when the DUT pulses ack. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_hermes_switch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req;
  logic [79:0] head;
  logic [4:0]  free;
  logic [4:0]  ack;
  logic [4:0]  out_en;
  logic [14:0] out_src;
`ifdef HERMES_SWITCH_STATS_EN
  logic [15:0] blocked_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] port;
    logic [2:0] dir;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hermes_switch_ctrl #(
    .ADDRESS  (32'h0101),
    .FLIT_SIZE(16),
    .NPORT    (5)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .head_i   (head),
    .free_i   (free),
    .ack_o    (ack),
    .out_en_o (out_en),
    .out_src_o(out_src)
`ifdef HERMES_SWITCH_STATS_EN
    ,
    .blocked_cnt_o(blocked_cnt)
`endif
  );

  function automatic logic [2:0] src_of(input logic [2:0] o);
    return out_src[o*3 +: 3];
  endfunction

  task automatic set_head(input int p, input logic [15:0] v);
    head[p*16 +: 16] = v;
  endtask

  // Waits on falling edges for an ack pulse, up to a cycle budget.
  task automatic wait_ack(input int budget, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (ack !== 5'b0) got = 1'b1;
    end
  endtask

  task automatic apply_reset();
    req   = '0;
    free  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses free_i for exactly one rising edge.
  task automatic pulse_free(input logic [4:0] m);
    free = m;
    @(negedge clk);
    free = '0;
  endtask

  task automatic test_reset();
    req   = '0;
    free  = '0;
    head  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 5'b0 || out_en !== 5'b0 || out_src !== 15'b0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b out_en=%b out_src=%h required 0/0/0", ack, out_en, out_src);
    end
`ifdef HERMES_SWITCH_STATS_EN
    checks++;
    if (blocked_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_blocked_cnt got=%0d required 0", blocked_cnt);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 5'b0 || out_en !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_reset ack=%b out_en=%b required 0/0", ack, out_en);
    end
  endtask

  task automatic test_basic_grant();
    bit   got;
    int   n;
    exp_t e;
    set_head(4, 16'h0301);
    req[4] = 1'b1;
    sb.push_back('{port: 3'd4, dir: 3'd0});
    wait_ack(10, got, n);
    e = sb.pop_front();
    checks++;
    if (!got || n !== 3) begin
      failures++;
      $display("FAIL basic_latency got_ack=%0d cycles=%0d required 1/3", got, n);
    end
    checks++;
    if (ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
      failures++;
      $display("FAIL basic_grant ack=%b out_en=%b src=%0d required ack=%b en[%0d]=1 src=%0d",
               ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
    end
    req[4] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 5'b0 || out_en !== 5'b00001) begin
      failures++;
      $display("FAIL basic_pulse ack=%b out_en=%b required 00000/00001", ack, out_en);
    end
  endtask

  task automatic test_routing();
    logic [15:0] heads[4] = '{16'h0001, 16'h0102, 16'h0100, 16'h0101};
    logic [2:0]  dirs[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
    bit   got;
    int   n;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      set_head(i, heads[i]);
      req[i] = 1'b1;
      sb.push_back('{port: 3'(i), dir: dirs[i]});
      wait_ack(10, got, n);
      e = sb.pop_front();
      checks++;
      if (!got || ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
        failures++;
        $display("FAIL route_%0d ack=%b out_en=%b src=%0d required ack=%b en[%0d]=1 src=%0d",
                 i, ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
      end
      req[i] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (out_en !== 5'b11111) begin
      failures++;
      $display("FAIL route_all_alloc out_en=%b required 11111", out_en);
    end
    pulse_free(5'b11111);
    checks++;
    if (out_en !== 5'b00000) begin
      failures++;
      $display("FAIL multi_free out_en=%b required 00000", out_en);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] heads[5] = '{16'hFF01, 16'h0001, 16'h01FF, 16'h0100, 16'h0101};
    bit   got;
    int   n;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 5; i++) set_head(i, heads[i]);
    for (int round = 0; round < 2; round++) begin
      req = 5'b11111;
      for (int i = 0; i < 5; i++) sb.push_back('{port: 3'(i), dir: 3'(i)});
      for (int i = 0; i < 5; i++) begin
        wait_ack(12, got, n);
        e = sb.pop_front();
        checks++;
        if (!got || ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
          failures++;
          $display("FAIL rr_r%0d_g%0d ack=%b out_en=%b src=%0d required ack=%b en[%0d]=1 src=%0d",
                   round, i, ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
        end
        req = req & ~ack;
        if (!got) req[e.port] = 1'b0;
      end
      req = '0;
      @(negedge clk);
      pulse_free(5'b11111);
      checks++;
      if (out_en !== 5'b00000) begin
        failures++;
        $display("FAIL rr_release_r%0d out_en=%b required 00000", round, out_en);
      end
    end
  endtask

  task automatic test_blocked();
    bit   got;
    bit   seen_ack;
    int   n;
    exp_t e;
    apply_reset();
    set_head(4, 16'h0301);
    req[4] = 1'b1;
    sb.push_back('{port: 3'd4, dir: 3'd0});
    wait_ack(10, got, n);
    e = sb.pop_front();
    checks++;
    if (!got || ack !== (5'b1 << e.port)) begin
      failures++;
      $display("FAIL blk_setup ack=%b required %b", ack, 5'b1 << e.port);
    end
    req[4] = 1'b0;
    @(negedge clk);
    set_head(1, 16'h0301);
    req[1] = 1'b1;
    seen_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack !== 5'b0) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack || out_en !== 5'b00001 || src_of(3'd0) !== 3'd4) begin
      failures++;
      $display("FAIL blk_no_grant seen_ack=%0d out_en=%b src0=%0d required 0/00001/4",
               seen_ack, out_en, src_of(3'd0));
    end
`ifdef HERMES_SWITCH_STATS_EN
    checks++;
    if (blocked_cnt !== 16'd2) begin
      failures++;
      $display("FAIL blk_count got=%0d required 2", blocked_cnt);
    end
`endif
    sb.push_back('{port: 3'd1, dir: 3'd0});
    pulse_free(5'b10000);
    checks++;
    if (out_en !== 5'b00000) begin
      failures++;
      $display("FAIL blk_release out_en=%b required 00000", out_en);
    end
    wait_ack(10, got, n);
    e = sb.pop_front();
    checks++;
    if (!got || n !== 2 || ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
      failures++;
      $display("FAIL blk_regrant cycles=%0d ack=%b out_en=%b src=%0d required 2/%b/en[%0d]=1/%0d",
               n, ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
    end
    req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    bit   got;
    int   n;
    exp_t e;
    apply_reset();
    set_head(4, 16'h0301);
    req[4] = 1'b1;
    wait_ack(10, got, n);
    req[4] = 1'b0;
    @(negedge clk);
    set_head(1, 16'h0301);
    req[1] = 1'b1;
    sb.push_back('{port: 3'd1, dir: 3'd0});
    repeat (2) @(negedge clk);
    checks++;
    if (out_en[0] !== 1'b1 || src_of(3'd0) !== 3'd4) begin
      failures++;
      $display("FAIL byp_before en0=%b src0=%0d required 1/4", out_en[0], src_of(3'd0));
    end
    pulse_free(5'b10000);
    e = sb.pop_front();
    checks++;
    if (ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
      failures++;
      $display("FAIL byp_grant ack=%b out_en=%b src0=%0d required %b/en[%0d]=1/%0d",
               ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
    end
`ifdef HERMES_SWITCH_STATS_EN
    checks++;
    if (blocked_cnt !== 16'd0) begin
      failures++;
      $display("FAIL byp_count got=%0d required 0", blocked_cnt);
    end
`endif
    req[1] = 1'b0;
    @(negedge clk);
    pulse_free(5'b00100);
    pulse_free(5'b10000);
    checks++;
    if (out_en !== 5'b00001 || src_of(3'd0) !== 3'd1) begin
      failures++;
      $display("FAIL free_ignored out_en=%b src0=%0d required 00001/1", out_en, src_of(3'd0));
    end
    pulse_free(5'b00010);
    checks++;
    if (out_en !== 5'b00000) begin
      failures++;
      $display("FAIL free_holder out_en=%b required 00000", out_en);
    end
  endtask

  task automatic test_req_drop();
    bit seen_ack = 1'b0;
    set_head(0, 16'h0301);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack !== 5'b0) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack || out_en !== 5'b00000) begin
      failures++;
      $display("FAIL req_drop seen_ack=%0d out_en=%b required 0/00000", seen_ack, out_en);
    end
  endtask

  task automatic test_reset_mid();
    bit   got;
    int   n;
    exp_t e;
    apply_reset();
    set_head(2, 16'h0301);
    req[2] = 1'b1;
    wait_ack(10, got, n);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!got || ack !== 5'b0 || out_en !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid got_ack=%0d ack=%b out_en=%b required 1/00000/00000", got, ack, out_en);
    end
    @(negedge clk);
    set_head(3, 16'h0001);
    req = 5'b01100;
    sb.push_back('{port: 3'd2, dir: 3'd0});
    sb.push_back('{port: 3'd3, dir: 3'd1});
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_ack(12, got, n);
      e = sb.pop_front();
      checks++;
      if (!got || ack !== (5'b1 << e.port) || out_en[e.dir] !== 1'b1 || src_of(e.dir) !== e.port) begin
        failures++;
        $display("FAIL post_reset_g%0d ack=%b out_en=%b src=%0d required ack=%b en[%0d]=1 src=%0d",
                 i, ack, out_en, src_of(e.dir), 5'b1 << e.port, e.dir, e.port);
      end
      req = req & ~ack;
      if (!got) req[e.port] = 1'b0;
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_routing();
    test_round_robin();
    test_blocked();
    test_bypass();
    test_req_drop();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
